// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package round_robin_arbiter_pkg;

  typedef enum logic {
    STATE_IDLE    = 1'b0,
    STATE_GRANTED = 1'b1
  } state_t;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between the clients and the round-robin arbiter.
interface round_robin_arbiter_if
  import round_robin_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int INDEX_WIDTH = clog2_min1(REQUESTERS)
) ();

  logic                   enable;
  logic [REQUESTERS-1:0]  request;
  logic [REQUESTERS-1:0]  grant;
  logic                   grantValid;
  logic [INDEX_WIDTH-1:0] grantIndex;
  logic                   preempted;

  // Client side: raises requests, observes the grant.
  modport master (
    output enable, request,
    input  grant, grantValid, grantIndex, preempted
  );

  // Arbiter side.
  modport slave (
    input  enable, request,
    output grant, grantValid, grantIndex, preempted
  );

endinterface

// File: rtl/round_robin_arbiter_priority_select.sv
// Combinational round-robin pick: rotate so lastIndex+1 is bit 0, take the
// lowest set bit, rotate the one-hot result back.
module rr_priority_select
  import round_robin_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int INDEX_WIDTH = clog2_min1(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0]  request,
  input  logic [INDEX_WIDTH-1:0] lastIndex,
  output logic [REQUESTERS-1:0]  winner,
  output logic [INDEX_WIDTH-1:0] winnerIndex,
  output logic                   anyRequest
);

  logic [INDEX_WIDTH-1:0] start;
  logic [REQUESTERS-1:0]  rotated;
  logic [REQUESTERS-1:0]  picked;

  always_comb begin
    start   = (lastIndex == INDEX_WIDTH'(REQUESTERS - 1)) ? '0 : lastIndex + INDEX_WIDTH'(1);
    rotated = REQUESTERS'({request, request} >> start);
    picked  = rotated & (~rotated + REQUESTERS'(1));
    // Shifting the doubled vector left wraps the pick back into the upper copy.
    winner  = REQUESTERS'(({picked, picked} << start) >> REQUESTERS);
    anyRequest = |request;
    winnerIndex = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (winner[i]) winnerIndex = INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with hold-until-release ownership, optional timeout
// preemption and a mandatory idle cycle between owners.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int MAX_HOLD    = 0,
  parameter int INDEX_WIDTH = clog2_min1(REQUESTERS)
) (
  input logic clk,
  input logic rst,
  round_robin_arbiter_if.slave bus
);

  localparam int HOLD_W     = clog2_min1(MAX_HOLD + 1);
  localparam int HOLD_LIMIT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  state_t                 state;
  logic [HOLD_W-1:0]      holdCount;
  logic [INDEX_WIDTH-1:0] lastIndex;
  logic [REQUESTERS-1:0]  grantReg;
  logic                   grantValidReg;
  logic [INDEX_WIDTH-1:0] grantIndexReg;
  logic                   preemptedReg;

  logic [REQUESTERS-1:0]  winner;
  logic [INDEX_WIDTH-1:0] winnerIndex;
  logic                   anyRequest;
  logic                   ownerRequest;
  logic                   otherRequest;

  rr_priority_select #(
    .REQUESTERS (REQUESTERS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_select (
    .request    (bus.request),
    .lastIndex  (lastIndex),
    .winner     (winner),
    .winnerIndex(winnerIndex),
    .anyRequest (anyRequest)
  );

  // Owner identified via the one-hot grant, so no indexing by grantIndex.
  assign ownerRequest = |(bus.request & grantReg);
  assign otherRequest = |(bus.request & ~grantReg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STATE_IDLE;
      holdCount     <= '0;
      lastIndex     <= INDEX_WIDTH'(REQUESTERS - 1);
      grantReg      <= '0;
      grantValidReg <= 1'b0;
      grantIndexReg <= '0;
      preemptedReg  <= 1'b0;
    end else begin
      preemptedReg <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (bus.enable && anyRequest) begin
            grantReg      <= winner;
            grantValidReg <= 1'b1;
            grantIndexReg <= winnerIndex;
            holdCount     <= '0;
            state         <= STATE_GRANTED;
          end
        end
        STATE_GRANTED: begin
          if (!ownerRequest) begin
            grantReg      <= '0;
            grantValidReg <= 1'b0;
            lastIndex     <= grantIndexReg;
            state         <= STATE_IDLE;
          end else if (MAX_HOLD != 0 && holdCount == HOLD_W'(HOLD_LIMIT) && otherRequest) begin
            grantReg      <= '0;
            grantValidReg <= 1'b0;
            preemptedReg  <= 1'b1;
            lastIndex     <= grantIndexReg;
            state         <= STATE_IDLE;
          end else if (holdCount != HOLD_W'(MAX_HOLD)) begin
            holdCount <= holdCount + HOLD_W'(1);
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign bus.grant      = grantReg;
  assign bus.grantValid = grantValidReg;
  assign bus.grantIndex = grantIndexReg;
  assign bus.preempted  = preemptedReg;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench: directed stimulus queues expected outputs, a negedge
// monitor pops and compares them against two arbiters (MAX_HOLD=8 and 0).
module tb_round_robin_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned nchecks = 0;
  int unsigned nfail = 0;
  logic [1:0] last_idx [2];

  typedef struct {
    int unsigned due;
    int unsigned which;
    logic [3:0]  g;
    logic [1:0]  idx;
    logic        pre;
    string       name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  round_robin_arbiter_if #(.REQUESTERS(4), .INDEX_WIDTH(2)) bus8 ();
  round_robin_arbiter_if #(.REQUESTERS(4), .INDEX_WIDTH(2)) bus0 ();

  round_robin_arbiter #(.REQUESTERS(4), .MAX_HOLD(8), .INDEX_WIDTH(2)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  round_robin_arbiter #(.REQUESTERS(4), .MAX_HOLD(0), .INDEX_WIDTH(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  function automatic logic [1:0] onehot_idx(input logic [3:0] g);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: compare every expectation that has come due.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] ag;
    logic       av;
    logic [1:0] ai;
    logic       ap;
    while (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.which == 0) begin
        ag = bus8.grant; av = bus8.grantValid; ai = bus8.grantIndex; ap = bus8.preempted;
      end else begin
        ag = bus0.grant; av = bus0.grantValid; ai = bus0.grantIndex; ap = bus0.preempted;
      end
      nchecks++;
      if (e.due != cyc || ag !== e.g || av !== (|e.g) || ai !== e.idx || ap !== e.pre) begin
        nfail++;
        $display("FAIL %s (dut%0d cyc %0d due %0d): got grant=%b valid=%b idx=%0d pre=%b, want grant=%b valid=%b idx=%0d pre=%b",
                 e.name, e.which, cyc, e.due, ag, av, ai, ap, e.g, |e.g, e.idx, e.pre);
      end
    end
  end

  // Drive inputs just after an edge; the expected output follows the next edge.
  task automatic step(input int unsigned w, input logic [3:0] req, input logic en,
                      input logic [3:0] g, input logic pre, input string name);
    @(posedge clk);
    #1;
    if (w == 0) begin
      bus8.request = req; bus8.enable = en;
    end else begin
      bus0.request = req; bus0.enable = en;
    end
    if (g != 4'b0000) last_idx[w] = onehot_idx(g);
    q.push_back('{due: cyc + 1, which: w, g: g, idx: last_idx[w], pre: pre, name: name});
  endtask

  task automatic check_idle_now(input int unsigned w, input string name);
    q.push_back('{due: cyc, which: w, g: 4'b0000, idx: 2'd0, pre: 1'b0, name: name});
  endtask

  initial begin
    bus8.request = '0; bus8.enable = 1'b0;
    bus0.request = '0; bus0.enable = 1'b0;
    last_idx[0] = 2'd0;
    last_idx[1] = 2'd0;

    @(posedge clk); #1;
    check_idle_now(0, "reset8");
    check_idle_now(1, "reset0");
    @(posedge clk); #1;
    rst = 1'b0;

    // All request: 8-cycle ownership, preempt, dead cycle, rotate.
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) step(0, 4'b1111, 1'b1, 4'b0001 << (k % 4), 1'b0, "rotate_hold");
      if (k < 4) step(0, 4'b1111, 1'b1, 4'b0000, 1'b1, "preempt");
    end
    // Owner drops on the same edge the timeout would fire: release wins.
    step(0, 4'b1110, 1'b1, 4'b0000, 1'b0, "release_beats_preempt");
    step(0, 4'b1110, 1'b1, 4'b0010, 1'b0, "regrant_after_release");
    step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "release_1");

    // Lone requester is never preempted.
    for (int j = 0; j < 20; j++) step(0, 4'b0100, 1'b1, 4'b0100, 1'b0, "solo_hold");
    step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "solo_release");

    // Release and new request in the same cycle still leave a dead cycle.
    step(0, 4'b0010, 1'b1, 4'b0010, 1'b0, "own_1");
    step(0, 4'b0010, 1'b1, 4'b0010, 1'b0, "own_1_hold");
    step(0, 4'b1000, 1'b1, 4'b0000, 1'b0, "handoff_gap");
    step(0, 4'b1000, 1'b1, 4'b1000, 1'b0, "handoff_new");
    step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "release_3");

    // enable low: preemption still happens, no new grant until enable returns.
    step(0, 4'b0001, 1'b1, 4'b0001, 1'b0, "own_0");
    for (int j = 0; j < 7; j++) step(0, 4'b0011, 1'b0, 4'b0001, 1'b0, "disabled_hold");
    step(0, 4'b0011, 1'b0, 4'b0000, 1'b1, "disabled_preempt");
    for (int j = 0; j < 3; j++) step(0, 4'b0011, 1'b0, 4'b0000, 1'b0, "disabled_idle");
    step(0, 4'b0011, 1'b1, 4'b0010, 1'b0, "enable_grant");
    step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "release_after_enable");

    // Asynchronous reset between edges while client 2 owns.
    step(0, 4'b0100, 1'b1, 4'b0100, 1'b0, "pre_reset_grant");
    step(0, 4'b0100, 1'b1, 4'b0100, 1'b0, "pre_reset_hold");
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    bus8.request = 4'b0000;
    last_idx[0] = 2'd0;
    last_idx[1] = 2'd0;
    check_idle_now(0, "async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 4'b1000, 1'b1, 4'b1000, 1'b0, "post_reset_grant");
    step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "post_reset_release");

    // MAX_HOLD=0: owner keeps the grant with others waiting.
    for (int j = 0; j < 100; j++) step(1, 4'b1111, 1'b1, 4'b0001, 1'b0, "nohold_keep");
    step(1, 4'b0000, 1'b1, 4'b0000, 1'b0, "nohold_release");

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nchecks++;
      nfail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
